bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits directly upstream of the per-digit hex/7-seg decoders: each 4-bit
//   digit of bcd_out drives one decoder's val_in, so the HEX displays show
//   decimal. Also provides a leading-zero blank mask and an overflow flag.
// PARAMETERS
//   IN_W    16  width of binary input, >= 1
//   DIGITS  5   number of BCD digits produced, >= 1
// PORTS
//   clk       in   1           rising-edge clock
//   rst_n     in   1           async active-low reset
//   start     in   1           request conversion of bin_in; accepted only when busy=0
//   bin_in    in   IN_W        unsigned value, sampled on the accepting edge only
//   busy      out  1           conversion in progress (state SHIFT)
//   done      out  1           one-cycle pulse: bcd_out/blank/overflow just updated
//   bcd_out   out  4*DIGITS    result; digit i = bcd_out[4i+3:4i], digit 0 = units
//   blank     out  DIGITS      1 = digit is a leading zero (bit 0 always 0)
//   overflow  out  1           value >= 10**DIGITS; bcd_out then holds value mod 10**DIGITS
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, busy=0, done=0, bcd_out=0,
//     blank={DIGITS-1{1},1'b0}, overflow=0, internal shift/scratch/count = 0.
//   - FSM: IDLE, SHIFT, DONE.
//     IDLE/DONE -> SHIFT on start=1: latch bin_in into shift reg, clear BCD
//       scratch, clear overflow scratch, count=0.
//     IDLE stays IDLE on start=0. DONE -> IDLE on start=0.
//     SHIFT: each edge, for every scratch digit >= 5 add 3 (4-bit, no carry),
//       then shift {scratch, shift_reg} left 1. A 1 shifted out of the top
//       digit sets overflow scratch (sticky for this conversion). count++.
//     SHIFT -> DONE on the edge performing shift IN_W (count==IN_W-1):
//       same edge registers final scratch into bcd_out, blank, overflow; done=1.
//   - Latency: start sampled at edge E0 -> done=1 in the cycle after edge
//     E0+IN_W (16 edges for default); done is low in every other cycle.
//   - busy=1 exactly in SHIFT (IN_W cycles). start while busy=1 is ignored,
//     not queued; bin_in changes while busy have no effect.
//   - Back-to-back: start=1 during the DONE cycle is accepted (no IDLE gap);
//     done still pulses one cycle only.
//   - bcd_out, blank, overflow change only on the DONE-entry edge and hold
//     otherwise (stable display between conversions).
//   - blank[i] (i>=1) = 1 iff digits i..DIGITS-1 of the new result are all 0;
//     computed from the wrapped result even when overflow=1.
//   - Reset mid-conversion: immediate return to reset values; no done pulse;
//     conversion is lost.
//   - DIGITS large enough (10**DIGITS > 2**IN_W-1) => overflow never asserts.
// TESTING
//   T1 default: start, bin_in=0 -> done after 16 edges, bcd_out=20'h00000, blank=5'b11110, overflow=0
//   T2 default: bin_in=16'hFFFF -> bcd_out=20'h65535, blank=5'b00000; busy high exactly 16 cycles
//   T3 default: bin_in=1234, then start+bin_in=9 held while busy -> one done, bcd_out=20'h01234, blank=5'b10000
//   T4 default: bin_in=42, start re-asserted in DONE cycle with bin_in=7 -> done pulses 17 edges apart, results 20'h00042 then 20'h00007
//   T5 default: rst_n=0 at 8th SHIFT cycle of bin_in=500 -> all outputs reset values at once, no done; restart converts 500 -> 20'h00500
//   T6 IN_W=8, DIGITS=2: bin_in=255 -> bcd_out=8'h55, overflow=1, blank=2'b00; next bin_in=99 -> 8'h99, overflow=0

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// It also produces a leading-zero blank mask and an overflow flag for the digit displays.
module bin2bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     shift_q, shift_d;
  logic [BW-1:0]       scratch_q, scratch_d;
  logic                ovf_scr_q, ovf_scr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                overflow_q, overflow_d;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       shifted;
  logic                shift_out;
  logic [DIGITS-1:0]   blank_new;

  // Per-digit add-3 correction; the 4-bit add drops any carry.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                            scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
    if (gi == 0) begin : g_units
      assign blank_new[gi] = 1'b0;
    end else begin : g_upper
      assign blank_new[gi] = (shifted[BW-1:4*gi] == '0);
    end
  end

  assign shifted   = {adj[BW-2:0], shift_q[IN_W-1]};
  assign shift_out = adj[BW-1];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_scr_d  = ovf_scr_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT;
          shift_d   = bin_in;
          scratch_d = '0;
          ovf_scr_d = 1'b0;
          count_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = shifted;
        ovf_scr_d = ovf_scr_q | shift_out;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d    = DONE;
          bcd_d      = shifted;
          blank_d    = blank_new;
          overflow_d = ovf_scr_q | shift_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_scr_q  <= 1'b0;
      count_q    <= '0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_scr_q  <= ovf_scr_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule
